// File: rtl/pcie_cfg_mgmt_arb.sv
// Round-robin arbiter/sequencer sharing the PCIe core cfg_mgmt port among PORTS requesters.
// Optional read_write_done watchdog enabled by defining PCIE_CFG_MGMT_ARB_TIMEOUT_EN.
module pcie_cfg_mgmt_arb #(
  parameter int unsigned PORTS   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PORTS*10-1:0] s_req_addr,
  input  logic [PORTS*8-1:0]  s_req_function_number,
  input  logic [PORTS-1:0]    s_req_write,
  input  logic [PORTS*32-1:0] s_req_write_data,
  input  logic [PORTS*4-1:0]  s_req_byte_enable,
  input  logic [PORTS-1:0]    s_req_valid,
  output logic [PORTS-1:0]    s_req_ready,
  output logic [31:0]         s_rsp_read_data,
  output logic [PORTS-1:0]    s_rsp_valid,
  output logic [PORTS-1:0]    s_rsp_error,
  output logic [9:0]          cfg_mgmt_addr,
  output logic [7:0]          cfg_mgmt_function_number,
  output logic                cfg_mgmt_write,
  output logic [31:0]         cfg_mgmt_write_data,
  output logic [3:0]          cfg_mgmt_byte_enable,
  output logic                cfg_mgmt_read,
  input  logic [31:0]         cfg_mgmt_read_data,
  input  logic                cfg_mgmt_read_write_done
);

  localparam int unsigned IDXW = (PORTS > 1) ? $clog2(PORTS) : 1;

  if (PORTS < 2 || PORTS > 8 || TIMEOUT < 1) begin : g_param_check
    $error("pcie_cfg_mgmt_arb: PORTS must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [9:0]        addr_q, addr_d;
  logic [7:0]        func_q, func_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [PORTS-1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;

  logic [PORTS-1:0]  grant;
  logic [IDXW-1:0]   grant_idx;
  logic              found;
  int unsigned       idx;
  logic [9:0]        sel_addr;
  logic [7:0]        sel_func;
  logic              sel_write;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_be;
  logic              timeout_hit;

`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PORTS-1:0]  rsp_err_q, rsp_err_d;

  // Abort on the cycle the counter would reach TIMEOUT: strobe is high for TIMEOUT cycles.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign s_rsp_error = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign s_rsp_error = '0;
`endif

  // Search from ptr_q upward (wrapping) for the first valid requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    sel_addr  = '0;
    sel_func  = '0;
    sel_write = 1'b0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!found && s_req_valid[idx[IDXW-1:0]]) begin
        found                  = 1'b1;
        grant[idx[IDXW-1:0]]   = 1'b1;
        grant_idx              = idx[IDXW-1:0];
        sel_addr               = s_req_addr[idx*10 +: 10];
        sel_func               = s_req_function_number[idx*8 +: 8];
        sel_write              = s_req_write[idx[IDXW-1:0]];
        sel_wdata              = s_req_write_data[idx*32 +: 32];
        sel_be                 = s_req_byte_enable[idx*4 +: 4];
      end
    end
  end

  // Ready is forced low while reset is asserted, even with valid requests present.
  assign s_req_ready = grant & {PORTS{rst_n && (state_q == IDLE)}};

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    func_d      = func_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = grant_idx;
          addr_d  = sel_addr;
          func_d  = sel_func;
          write_d = sel_write;
          wdata_d = sel_wdata;
          be_d    = sel_be;
          ptr_d   = (grant_idx == IDXW'(PORTS - 1)) ? '0 : grant_idx + 1'b1;
          state_d = ACTIVE;
`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ACTIVE: begin
`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (cfg_mgmt_read_write_done) begin
          state_d              = IDLE;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = write_q ? '0 : cfg_mgmt_read_data;
        end else if (timeout_hit) begin
          state_d              = IDLE;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = '0;
`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
          rsp_err_d[owner_q]   = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      func_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      func_q      <= func_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cfg_mgmt_addr            = addr_q;
  assign cfg_mgmt_function_number = func_q;
  assign cfg_mgmt_write_data      = wdata_q;
  assign cfg_mgmt_byte_enable     = be_q;
  assign cfg_mgmt_write           = (state_q == ACTIVE) &&  write_q;
  assign cfg_mgmt_read            = (state_q == ACTIVE) && !write_q;
  assign s_rsp_valid              = rsp_valid_q;
  assign s_rsp_read_data          = rsp_data_q;

endmodule

// File: tb/tb_pcie_cfg_mgmt_arb.sv
// Directed self-checking bench for pcie_cfg_mgmt_arb (PORTS=4, TIMEOUT=15).
module tb_pcie_cfg_mgmt_arb;
  localparam int unsigned PORTS = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [PORTS*10-1:0] s_req_addr;
  logic [PORTS*8-1:0]  s_req_function_number;
  logic [PORTS-1:0]    s_req_write;
  logic [PORTS*32-1:0] s_req_write_data;
  logic [PORTS*4-1:0]  s_req_byte_enable;
  logic [PORTS-1:0]    s_req_valid;
  logic [PORTS-1:0]    s_req_ready;
  logic [31:0]         s_rsp_read_data;
  logic [PORTS-1:0]    s_rsp_valid;
  logic [PORTS-1:0]    s_rsp_error;
  logic [9:0]          cfg_mgmt_addr;
  logic [7:0]          cfg_mgmt_function_number;
  logic                cfg_mgmt_write;
  logic [31:0]         cfg_mgmt_write_data;
  logic [3:0]          cfg_mgmt_byte_enable;
  logic                cfg_mgmt_read;
  logic [31:0]         cfg_mgmt_read_data;
  logic                cfg_mgmt_read_write_done;

  int tests_run = 0;
  int failures  = 0;

  pcie_cfg_mgmt_arb #(.PORTS(PORTS), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_req_addr(s_req_addr), .s_req_function_number(s_req_function_number),
    .s_req_write(s_req_write), .s_req_write_data(s_req_write_data),
    .s_req_byte_enable(s_req_byte_enable), .s_req_valid(s_req_valid),
    .s_req_ready(s_req_ready), .s_rsp_read_data(s_rsp_read_data),
    .s_rsp_valid(s_rsp_valid), .s_rsp_error(s_rsp_error),
    .cfg_mgmt_addr(cfg_mgmt_addr), .cfg_mgmt_function_number(cfg_mgmt_function_number),
    .cfg_mgmt_write(cfg_mgmt_write), .cfg_mgmt_write_data(cfg_mgmt_write_data),
    .cfg_mgmt_byte_enable(cfg_mgmt_byte_enable), .cfg_mgmt_read(cfg_mgmt_read),
    .cfg_mgmt_read_data(cfg_mgmt_read_data),
    .cfg_mgmt_read_write_done(cfg_mgmt_read_write_done)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int unsigned p, input logic [9:0] a, input logic [7:0] f,
                         input logic w, input logic [31:0] d, input logic [3:0] be);
    s_req_addr[p*10 +: 10]           = a;
    s_req_function_number[p*8 +: 8]  = f;
    s_req_write[p]                   = w;
    s_req_write_data[p*32 +: 32]     = d;
    s_req_byte_enable[p*4 +: 4]      = be;
    s_req_valid[p]                   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (s_req_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_ready: got %b want 0000", s_req_ready);
    end
    tests_run++;
    if ({cfg_mgmt_read, cfg_mgmt_write, cfg_mgmt_addr, cfg_mgmt_function_number,
         cfg_mgmt_write_data, cfg_mgmt_byte_enable} !== 56'h0) begin
      failures++; $display("FAIL reset_cfg: rd=%b wr=%b addr=%h nonzero outputs", cfg_mgmt_read, cfg_mgmt_write, cfg_mgmt_addr);
    end
    tests_run++;
    if ({s_rsp_valid, s_rsp_error, s_rsp_read_data} !== 40'h0) begin
      failures++; $display("FAIL reset_rsp: valid=%b err=%b data=%h want 0", s_rsp_valid, s_rsp_error, s_rsp_read_data);
    end
    s_req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    int strobes = 0;
    set_req(1, 10'h004, 8'h00, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    tests_run++;
    if (s_req_ready !== 4'b0010) begin
      failures++; $display("FAIL read_grant: got %b want 0010", s_req_ready);
    end
    @(posedge clk); #1;
    s_req_valid[1] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      cfg_mgmt_read_write_done = (c == 3);
      cfg_mgmt_read_data = (c == 3) ? 32'h00100007 : 32'hBAD0BAD0;
      @(negedge clk);
      if (cfg_mgmt_read) strobes++;
      if (c == 1) begin
        tests_run++;
        if ({cfg_mgmt_write, cfg_mgmt_addr, cfg_mgmt_function_number} !== {1'b0, 10'h004, 8'h00}) begin
          failures++; $display("FAIL read_fields: wr=%b addr=%h fn=%h want 0/004/00", cfg_mgmt_write, cfg_mgmt_addr, cfg_mgmt_function_number);
        end
      end
      if (c == 4) begin
        tests_run++;
        if ({s_rsp_valid, s_rsp_error, s_rsp_read_data} !== {4'b0010, 4'b0000, 32'h00100007}) begin
          failures++; $display("FAIL read_rsp: valid=%b err=%b data=%h want 0010/0000/00100007", s_rsp_valid, s_rsp_error, s_rsp_read_data);
        end
      end
      if (c == 5) begin
        tests_run++;
        if (s_rsp_valid !== 4'b0000) begin
          failures++; $display("FAIL read_rsp_pulse: got %b want 0000", s_rsp_valid);
        end
      end
      @(posedge clk); #1;
    end
    cfg_mgmt_read_write_done = 1'b0;
    tests_run++;
    if (strobes !== 3) begin
      failures++; $display("FAIL read_strobe_len: got %0d want 3", strobes);
    end
  endtask

  task automatic test_write();
    set_req(0, 10'h010, 8'h03, 1'b1, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    tests_run++;
    if (s_req_ready !== 4'b0001) begin
      failures++; $display("FAIL write_grant: got %b want 0001", s_req_ready);
    end
    @(posedge clk); #1;
    s_req_valid[0] = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cfg_mgmt_read_write_done = (c == 5);
      cfg_mgmt_read_data = 32'h12345678;
      @(negedge clk);
      if (c <= 5) begin
        tests_run++;
        if ({cfg_mgmt_write, cfg_mgmt_read, cfg_mgmt_addr, cfg_mgmt_function_number,
             cfg_mgmt_write_data, cfg_mgmt_byte_enable} !==
            {1'b1, 1'b0, 10'h010, 8'h03, 32'hDEADBEEF, 4'hF}) begin
          failures++; $display("FAIL write_hold c%0d: wr=%b rd=%b addr=%h fn=%h data=%h be=%h", c,
                               cfg_mgmt_write, cfg_mgmt_read, cfg_mgmt_addr, cfg_mgmt_function_number,
                               cfg_mgmt_write_data, cfg_mgmt_byte_enable);
        end
      end else begin
        tests_run++;
        if ({cfg_mgmt_write, s_rsp_valid, s_rsp_read_data} !== {1'b0, 4'b0001, 32'h0}) begin
          failures++; $display("FAIL write_rsp: wr=%b valid=%b data=%h want 0/0001/0", cfg_mgmt_write, s_rsp_valid, s_rsp_read_data);
        end
      end
      @(posedge clk); #1;
    end
    cfg_mgmt_read_write_done = 1'b0;
  endtask

  task automatic test_spurious_done();
    cfg_mgmt_read_write_done = 1'b1;
    cfg_mgmt_read_data = 32'hFFFFFFFF;
    @(negedge clk);
    @(posedge clk); #1;
    cfg_mgmt_read_write_done = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({s_rsp_valid, cfg_mgmt_read, cfg_mgmt_write, s_rsp_read_data} !== {4'b0000, 1'b0, 1'b0, 32'h0}) begin
      failures++; $display("FAIL spurious_done: valid=%b rd=%b wr=%b data=%h want all 0", s_rsp_valid, cfg_mgmt_read, cfg_mgmt_write, s_rsp_read_data);
    end
    @(posedge clk); #1;
  endtask

  // Pointer is 1 here (last grant was requester 0), so grants go 1,2,3,0,...
  task automatic test_back_to_back();
    logic [3:0] exp_g;
    logic [3:0] prev_g = 4'b0000;
    for (int unsigned p = 0; p < PORTS; p++) set_req(p, 10'(p), 8'h00, 1'b0, 32'h0, 4'h0);
    for (int op = 0; op < 8; op++) begin
      exp_g = 4'b0001 << ((1 + op) % 4);
      @(negedge clk);
      tests_run++;
      if ({cfg_mgmt_read, s_req_ready} !== {1'b0, exp_g}) begin
        failures++; $display("FAIL fair_grant op%0d: rd=%b ready=%b want 0/%b", op, cfg_mgmt_read, s_req_ready, exp_g);
      end
      if (op > 0) begin
        tests_run++;
        if (s_rsp_valid !== prev_g) begin
          failures++; $display("FAIL fair_rsp op%0d: got %b want %b", op, s_rsp_valid, prev_g);
        end
      end
      prev_g = exp_g;
      @(posedge clk); #1;
      cfg_mgmt_read_write_done = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({cfg_mgmt_read, s_req_ready} !== {1'b1, 4'b0000}) begin
        failures++; $display("FAIL fair_active op%0d: rd=%b ready=%b want 1/0000", op, cfg_mgmt_read, s_req_ready);
      end
      @(posedge clk); #1;
      cfg_mgmt_read_write_done = 1'b0;
    end
    s_req_valid = '0;
    @(negedge clk);
    tests_run++;
    if (s_rsp_valid !== prev_g) begin
      failures++; $display("FAIL fair_last_rsp: got %b want %b", s_rsp_valid, prev_g);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_active();
    set_req(2, 10'h020, 8'h01, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    tests_run++;
    if (s_req_ready !== 4'b0100) begin
      failures++; $display("FAIL rst_grant: got %b want 0100", s_req_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (cfg_mgmt_read !== 1'b1) begin
      failures++; $display("FAIL rst_pre_active: rd=%b want 1", cfg_mgmt_read);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({cfg_mgmt_read, cfg_mgmt_write, s_req_ready} !== {1'b0, 1'b0, 4'b0000}) begin
      failures++; $display("FAIL rst_async: rd=%b wr=%b ready=%b want 0/0/0000", cfg_mgmt_read, cfg_mgmt_write, s_req_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_req_valid = '1;
    @(negedge clk);
    tests_run++;
    if ({s_req_ready, s_rsp_valid} !== {4'b0001, 4'b0000}) begin
      failures++; $display("FAIL rst_ptr: ready=%b valid=%b want 0001/0000", s_req_ready, s_rsp_valid);
    end
    s_req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if ({s_rsp_valid, cfg_mgmt_read, cfg_mgmt_write} !== 6'b0) begin
        failures++; $display("FAIL rst_stale c%0d: valid=%b rd=%b wr=%b want 0", c, s_rsp_valid, cfg_mgmt_read, cfg_mgmt_write);
      end
    end
    @(posedge clk); #1;
  endtask

`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int strobes = 0;
    set_req(3, 10'h3FF, 8'h07, 1'b0, 32'h0, 4'h0);
    cfg_mgmt_read_data = 32'hFFFFFFFF;
    @(negedge clk);
    tests_run++;
    if (s_req_ready !== 4'b1000) begin
      failures++; $display("FAIL to_grant: got %b want 1000", s_req_ready);
    end
    @(posedge clk); #1;
    for (int c = 1; c <= 17; c++) begin
      cfg_mgmt_read_write_done = (c == 17);
      if (c == 17) s_req_valid[3] = 1'b0;
      @(negedge clk);
      if (c <= 16 && cfg_mgmt_read) strobes++;
      if (c == 16) begin
        tests_run++;
        if ({s_rsp_valid, s_rsp_error, s_rsp_read_data, s_req_ready} !==
            {4'b1000, 4'b1000, 32'h0, 4'b1000}) begin
          failures++; $display("FAIL to_rsp: valid=%b err=%b data=%h ready=%b want 1000/1000/0/1000",
                               s_rsp_valid, s_rsp_error, s_rsp_read_data, s_req_ready);
        end
      end
      if (c == 17) begin
        tests_run++;
        if ({cfg_mgmt_read, s_rsp_valid} !== {1'b1, 4'b0000}) begin
          failures++; $display("FAIL to_next_accept: rd=%b valid=%b want 1/0000", cfg_mgmt_read, s_rsp_valid);
        end
      end
      @(posedge clk); #1;
    end
    cfg_mgmt_read_write_done = 1'b0;
    tests_run++;
    if (strobes !== 15) begin
      failures++; $display("FAIL to_strobe_len: got %0d want 15", strobes);
    end
    @(negedge clk);
    tests_run++;
    if ({s_rsp_valid, s_rsp_error, s_rsp_read_data} !== {4'b1000, 4'b0000, 32'hFFFFFFFF}) begin
      failures++; $display("FAIL to_done_rsp: valid=%b err=%b data=%h want 1000/0000/ffffffff", s_rsp_valid, s_rsp_error, s_rsp_read_data);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    s_req_addr = '0; s_req_function_number = '0; s_req_write = '0;
    s_req_write_data = '0; s_req_byte_enable = '0; s_req_valid = '0;
    cfg_mgmt_read_data = '0; cfg_mgmt_read_write_done = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_spurious_done();
    test_back_to_back();
    test_reset_mid_active();
`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pcie_cfg_mgmt_arb.md
# pcie_cfg_mgmt_arb

Round-robin arbiter and sequencer that shares the PCIe hard core's configuration management port (cfg_mgmt_*) among PORTS independent requesters, such as the driver-facing register block, the MSI setup logic and the link-status monitor. It accepts one request at a time and holds the core's read/write strobe until read_write_done. It then returns read data and completion status to the originating requester. It sits in the 250 MHz user clock domain between fpga_core clients and the pcie4_uscale_plus instance.

## Interface
- PORTS, 4: number of requesters, 2..8.
- TIMEOUT, 1023: cycles to wait for read_write_done before aborting; used only with the watchdog macro.

Ports:
- clk  in  1  PCIe user clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_req_addr  in  PORTS*10  per-requester config dword address; requester i occupies bits [i*10 +: 10].
- s_req_function_number  in  PORTS*8  per-requester function number.
- s_req_write  in  PORTS  1 = write, 0 = read.
- s_req_write_data  in  PORTS*32  write data.
- s_req_byte_enable  in  PORTS*4  write byte enables.
- s_req_valid  in  PORTS  request valid.
- s_req_ready  out  PORTS  request accepted when valid and ready are both high.
- s_rsp_read_data  out  32  read data, shared by all requesters; qualified by s_rsp_valid.
- s_rsp_valid  out  PORTS  one-cycle completion pulse to the owning requester.
- s_rsp_error  out  PORTS  1 = aborted by timeout; qualified by s_rsp_valid.
- cfg_mgmt_addr  out  10  to the core.
- cfg_mgmt_function_number  out  8  to the core.
- cfg_mgmt_write  out  1  to the core.
- cfg_mgmt_write_data  out  32  to the core.
- cfg_mgmt_byte_enable  out  4  to the core.
- cfg_mgmt_read  out  1  to the core.
- cfg_mgmt_read_data  in  32  from the core.
- cfg_mgmt_read_write_done  in  1  from the core.

## Operation
- States: IDLE and ACTIVE.
- IDLE:
  - The grant is a combinational one-hot choice among s_req_valid, round-robin, starting at the index after the last granted requester.
  - s_req_ready = grant, valid only in IDLE. s_req_ready therefore depends combinationally on s_req_valid.
  - On acceptance, latch the addr, function number, write flag, data, byte enables and owner index, then go to ACTIVE.
- ACTIVE:
  - cfg_mgmt_write or cfg_mgmt_read is high according to the latched write flag, with all cfg_mgmt fields stable.
  - The strobe is held until cfg_mgmt_read_write_done is sampled high.
  - On done: drop the strobe, pulse s_rsp_valid[owner], register cfg_mgmt_read_data into s_rsp_read_data (reads only; writes return 0), set s_rsp_error=0, and go to IDLE.
- The round-robin pointer advances to owner+1 (mod PORTS) on acceptance.
- cfg_mgmt_read_write_done while IDLE is ignored.
- cfg_mgmt_read and cfg_mgmt_write are never high together.
- A requester may hold s_req_valid across its own response; it re-arbitrates normally.

## Timing
- Reset (asynchronous): state IDLE, pointer 0, all cfg_mgmt outputs 0, s_req_ready 0, s_rsp_valid 0, s_rsp_error 0, s_rsp_read_data 0.
- An operation in flight at reset is dropped; no response is produced.
- Cycle sequence:
  - Accept at cycle 0.
  - Strobe high from cycle 1.
  - Done sampled at cycle k ≥ 1.
  - Strobe low and s_rsp_valid high at cycle k+1.
  - The next accept is possible at cycle k+1, with its strobe at k+2.
- The strobe is always low for at least one cycle between operations.
- Throughput: one operation per (core latency + 2) cycles at best.

## Configuration
- PCIE_CFG_MGMT_ARB_TIMEOUT_EN defined:
  - A cycle counter of width $clog2(TIMEOUT+1) clears on accept and increments in ACTIVE.
  - If it reaches TIMEOUT with no done, drop the strobe, pulse s_rsp_valid[owner] with s_rsp_error=1 and s_rsp_read_data=0, then go to IDLE.
  - If done and the timeout hit in the same cycle, done wins and s_rsp_error=0.
  - Known limitation: a done arriving late during the next operation completes that operation.
- Macro undefined: no counter; ACTIVE waits indefinitely; s_rsp_error is constant 0.

## Test plan
- Read test: requester 1 reads addr 0x004, function 0; core returns 0x00100007 three cycles after the strobe. Required: s_rsp_valid[1] for one cycle with s_rsp_read_data = 0x00100007, strobe high for exactly 3 cycles.
- Write test: requester 0 writes 0xDEADBEEF with byte enable 0xF to addr 0x010. Required: cfg_mgmt_write held with stable fields until done; cfg_mgmt_read stays 0; response data 0.
- Fairness test: all 4 requesters continuously valid. Required: grants in order 0,1,2,3,0,…, no requester granted twice in succession, and strobe low ≥1 cycle between operations.
- Spurious-done test: pulse done while IDLE. Required: no response, state unchanged.
- Reset test: assert rst_n low mid-ACTIVE. Required: strobes and ready drop immediately (asynchronously); after release, no stale s_rsp_valid and the pointer is 0.
- Timeout test (macro on, TIMEOUT=15): never assert done. Required: strobe high for 15 cycles, then s_rsp_valid and s_rsp_error for the owner, data 0, and the next request accepted.
